// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the two-client ALU request scheduler.
package alu_sched_pkg;

    localparam int OPND_W = 32;
    localparam int RES_W  = 64;
    localparam int OPC_W  = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_DIVREM = 3'd3,
        OP_SHR    = 3'd4,
        OP_SHL    = 3'd5,
        OP_AND    = 3'd6,
        OP_OR     = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// client that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the winner for this cycle.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one external combinational ALU between two clients: round-robin
// grant, operands held for LAT cycles, result returned on a response channel.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int W     = 32,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [W-1:0]      req0_a,
    input  logic [W-1:0]      req0_b,
    input  logic [2:0]        req0_op,
    input  logic [W-1:0]      req1_a,
    input  logic [W-1:0]      req1_b,
    input  logic [2:0]        req1_op,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [2*W-1:0]    rsp_res,
    output logic              rsp_ov,
    output logic              rsp_dz,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [2*W-1:0]    alu_res,
    input  logic              alu_ov,
    output logic              busy,
    output logic              grant_id,
    output logic [CNT_W-1:0]  op_count
);

    // The EXEC counter starts at LAT-1 so operands sit on the ALU for LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_e         state_q;
    state_e         state_d;
    logic           gnt_valid;
    logic           gnt_id;
    logic           accept;
    logic           capture;
    logic           done;
    logic [3:0]     cnt_q;
    logic           dz_q;
    logic           last_grant;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [2:0]     sel_op;

    rr_arb2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_a  = gnt_id ? req1_a  : req0_a;
    assign sel_b  = gnt_id ? req1_b  : req0_b;
    assign sel_op = gnt_id ? req1_op : req0_op;
    assign busy   = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus handshake strobes; ready is only offered to the winner in IDLE.
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    req_ready = gnt_id ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = grant_id ? 2'b10 : 2'b01;
                if (rsp_ready[grant_id]) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand launch, settle countdown, result capture and completion bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            dz_q       <= 1'b0;
            grant_id   <= 1'b0;
            cnt_q      <= '0;
            rsp_res    <= '0;
            rsp_ov     <= 1'b0;
            rsp_dz     <= 1'b0;
            last_grant <= 1'b1;
            op_count   <= '0;
        end else begin
            if (accept) begin
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                alu_opcode <= sel_op;
                dz_q       <= (sel_op == 3'(OP_DIVREM)) && (sel_b == '0);
                grant_id   <= gnt_id;
                cnt_q      <= CNT_INIT;
            end else if (state_q == EXEC && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                rsp_res <= alu_res;
                rsp_ov  <= alu_ov;
                rsp_dz  <= dz_q;
            end
            if (done) begin
                last_grant <= grant_id;
                op_count   <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a behavioural ALU on the side.
module tb_alu_req_scheduler;
    import alu_sched_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_res;
    logic        rsp_ov, rsp_dz;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic [63:0] alu_res;
    logic        alu_ov;
    logic        busy;
    logic        grant_id;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_req_scheduler #(.W(32), .LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_ov(rsp_ov), .rsp_dz(rsp_dz),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_res(alu_res), .alu_ov(alu_ov),
        .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    // Reference ALU: add/sub report signed overflow, DIVREM packs {rem, quot}.
    always_comb begin
        logic [31:0] t;
        t       = 32'd0;
        alu_res = 64'd0;
        alu_ov  = 1'b0;
        case (alu_opcode)
            3'd0: begin
                t       = alu_a + alu_b;
                alu_res = {32'd0, t};
                alu_ov  = (alu_a[31] == alu_b[31]) && (t[31] != alu_a[31]);
            end
            3'd1: begin
                t       = alu_a - alu_b;
                alu_res = {32'd0, t};
                alu_ov  = (alu_a[31] != alu_b[31]) && (t[31] != alu_a[31]);
            end
            3'd2: alu_res = {32'd0, alu_a} * {32'd0, alu_b};
            3'd3: if (alu_b != 32'd0) alu_res = {alu_a % alu_b, alu_a / alu_b};
            3'd4: alu_res = {32'd0, alu_a >> alu_b[4:0]};
            3'd5: alu_res = {32'd0, alu_a << alu_b[4:0]};
            3'd6: alu_res = {32'd0, alu_a & alu_b};
            default: alu_res = {32'd0, alu_a | alu_b};
        endcase
    end

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [63:0] res;
        logic        ov;
        logic        dz;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int c, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        if (c == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req_valid[0] = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req_valid[1] = 1'b1;
        end
    endtask

    // Waits for ready (expected without delay), lets the edge take it, drops valid.
    task automatic accept(input int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[c] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        req_valid[c] = 1'b0;
    endtask

    // Waits for the response, checks it and the held ALU ports, then handshakes.
    task automatic get_rsp(input int c, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [63:0] res,
                           input logic ov, input logic dz, input int exp_lat);
        int n;
        logic [1:0] onehot;
        n = 0;
        onehot = (c == 0) ? 2'b01 : 2'b10;
        while (!rsp_valid[c] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_lat >= 0) chk("latency", 64'(n), 64'(exp_lat));
        chk("rsp_valid", 64'(rsp_valid), 64'(onehot));
        chk("rsp_res", rsp_res, res);
        chk("rsp_ov", 64'(rsp_ov), 64'(ov));
        chk("rsp_dz", 64'(rsp_dz), 64'(dz));
        chk("alu_a_hold", 64'(alu_a), 64'(a));
        chk("alu_b_hold", 64'(alu_b), 64'(b));
        chk("alu_op_hold", 64'(alu_opcode), 64'(op));
        chk("grant_id", 64'(grant_id), 64'(c));
        chk("ready_in_resp", 64'(req_ready), 64'd0);
        rsp_ready[c] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[c] = 1'b0;
        exp_cnt++;
        chk("op_count", 64'(op_count), 64'(exp_cnt));
        chk("busy_after", 64'(busy), 64'd0);
        chk("rsp_valid_after", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{0, 32'd5,          32'd7,          OP_ADD,    64'h0C,                    1'b0, 1'b0};
        tbl[1]  = '{1, 32'd100,        32'd7,          OP_DIVREM, {32'd2, 32'd14},          1'b0, 1'b0};
        tbl[2]  = '{0, 32'd100,        32'd0,          OP_DIVREM, 64'd0,                    1'b0, 1'b1};
        tbl[3]  = '{1, 32'h8000_0000,  32'd1,          OP_SUB,    64'h7FFF_FFFF,            1'b1, 1'b0};
        tbl[4]  = '{0, 32'h7FFF_FFFF,  32'd1,          OP_ADD,    64'h8000_0000,            1'b1, 1'b0};
        tbl[5]  = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  OP_MUL,    64'hFFFF_FFFE_0000_0001,  1'b0, 1'b0};
        tbl[6]  = '{0, 32'd1,          32'd31,         OP_SHL,    64'h8000_0000,            1'b0, 1'b0};
        tbl[7]  = '{1, 32'h8000_0000,  32'd4,          OP_SHR,    64'h0800_0000,            1'b0, 1'b0};
        tbl[8]  = '{0, 32'hF0,         32'h0F,         OP_OR,     64'hFF,                   1'b0, 1'b0};
        tbl[9]  = '{1, 32'd0,          32'd0,          OP_DIVREM, 64'd0,                    1'b0, 1'b1};
        tbl[10] = '{0, 32'd3,          32'd0,          OP_ADD,    64'd3,                    1'b0, 1'b0};

        rst_n = 1'b0;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_res", rsp_res, 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both clients valid straight out of reset: client 0 first, then client 1.
        set_req(0, 32'd3, 32'd4, OP_MUL);
        set_req(1, 32'hF0, 32'h3C, OP_AND);
        #1;
        chk("tie_first_ready", 64'(req_ready), 64'h1);
        accept(0);
        get_rsp(0, 32'd3, 32'd4, OP_MUL, 64'd12, 1'b0, 1'b0, LAT);
        chk("loser_ready", 64'(req_ready), 64'h2);
        accept(1);
        get_rsp(1, 32'hF0, 32'h3C, OP_AND, 64'h30, 1'b0, 1'b0, LAT);
        set_req(0, 32'd1, 32'd2, OP_ADD);
        set_req(1, 32'd3, 32'd4, OP_ADD);
        #1;
        chk("tie_again_ready", 64'(req_ready), 64'h1);
        accept(0);
        get_rsp(0, 32'd1, 32'd2, OP_ADD, 64'd3, 1'b0, 1'b0, LAT);
        accept(1);
        get_rsp(1, 32'd3, 32'd4, OP_ADD, 64'd7, 1'b0, 1'b0, LAT);

        for (int i = 0; i < 11; i++) begin
            set_req(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].op);
            accept(tbl[i].c);
            get_rsp(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].op,
                    tbl[i].res, tbl[i].ov, tbl[i].dz, LAT);
        end

        // Response backpressure with client 1 waiting; its rsp_ready must be ignored.
        set_req(0, 32'd10, 32'd20, OP_ADD);
        accept(0);
        begin
            int n;
            n = 0;
            while (!rsp_valid[0] && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("bp_latency", 64'(n), 64'(LAT));
        end
        set_req(1, 32'd9, 32'd4, OP_SUB);
        for (int i = 0; i < 10; i++) begin
            rsp_ready = (i == 5) ? 2'b10 : 2'b00;
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_rsp_res", rsp_res, 64'd30);
            chk("bp_alu_a", 64'(alu_a), 64'd10);
            chk("bp_alu_b", 64'(alu_b), 64'd20);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 2'b00;
        get_rsp(0, 32'd10, 32'd20, OP_ADD, 64'd30, 1'b0, 1'b0, -1);
        chk("bp_release_ready", 64'(req_ready), 64'h2);
        accept(1);
        get_rsp(1, 32'd9, 32'd4, OP_SUB, 64'd5, 1'b0, 1'b0, LAT);

        // Reset in the middle of EXEC discards the operation.
        set_req(0, 32'd2, 32'd2, OP_ADD);
        accept(0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
        chk("mid_rst_alu_op", 64'(alu_opcode), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_op_count", 64'(op_count), 64'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        set_req(0, 32'd2, 32'd2, OP_ADD);
        set_req(1, 32'd5, 32'd6, OP_ADD);
        #1;
        chk("post_rst_tie_ready", 64'(req_ready), 64'h1);
        accept(0);
        get_rsp(0, 32'd2, 32'd2, OP_ADD, 64'd4, 1'b0, 1'b0, LAT);
        chk("post_rst_loser_ready", 64'(req_ready), 64'h2);
        accept(1);
        get_rsp(1, 32'd5, 32'd6, OP_ADD, 64'd11, 1'b0, 1'b0, LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
